// File: rtl/signed_divider32.sv
// Signed 32/16 restoring divider with fixed latency.
// Divides a two's-complement dividend by a two's-complement divisor using
// magnitudes, one shift-subtract step per clock, then applies signs and
// saturates the quotient to the divisor width in a final fix-up cycle.
module signed_divider32 #(
    parameter int unsigned NW = 32,
    parameter int unsigned DW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic [NW-1:0] N,
    input  logic [DW-1:0] D,
    output logic [DW-1:0] Q,
    output logic [DW-1:0] R,
    output logic          busy,
    output logic          done,
    output logic          ovf,
    output logic          dz
);

    localparam int unsigned CW = $clog2(NW);

    // Largest positive and magnitude of most negative quotient, widened to NW.
    localparam logic [NW-1:0] PosMax = {{(NW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic [NW-1:0] NegMax = {{(NW-DW){1'b0}}, 1'b1, {(DW-1){1'b0}}};

    localparam logic [DW-1:0] QPosSat = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] QNegSat = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StDiv,
        StFix
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NW-1:0]   quo_q, quo_d;     // dividend bits shift out, quotient bits shift in
    logic [DW-1:0]   rem_q, rem_d;     // partial remainder magnitude
    logic [DW-1:0]   dmag_q, dmag_d;
    logic            nsign_q, nsign_d;
    logic            qsign_q, qsign_d;
    logic            dzero_q, dzero_d;

    logic [DW-1:0]   q_q, q_d;
    logic [DW-1:0]   r_q, r_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic            dz_q, dz_d;

    // Datapath helpers for one restoring step and for operand capture
    logic [DW:0]     rem_shift;
    logic [DW:0]     rem_diff;
    logic            take;
    logic [NW-1:0]   n_mag;
    logic [DW-1:0]   d_mag;

    // Combinational magnitudes and single restoring-division step
    always_comb begin
        n_mag     = N[NW-1] ? -N : N;
        d_mag     = D[DW-1] ? -D : D;
        rem_shift = {rem_q, quo_q[NW-1]};
        rem_diff  = rem_shift - {1'b0, dmag_q};
        take      = (rem_shift >= {1'b0, dmag_q});
    end

    // Next-state logic for the FSM, datapath and result registers
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dmag_d  = dmag_q;
        nsign_d = nsign_q;
        qsign_d = qsign_q;
        dzero_d = dzero_q;
        q_d     = q_q;
        r_d     = r_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        dz_d    = dz_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    quo_d   = n_mag;
                    rem_d   = '0;
                    dmag_d  = d_mag;
                    nsign_d = N[NW-1];
                    qsign_d = N[NW-1] ^ D[DW-1];
                    dzero_d = (D == '0);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StDiv;
                end
            end

            StDiv: begin
                // A zero divisor still runs the full loop to keep latency fixed
                quo_d = {quo_q[NW-2:0], take};
                rem_d = take ? rem_diff[DW-1:0] : rem_shift[DW-1:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NW - 1)) begin
                    state_d = StFix;
                end
            end

            StFix: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
                if (dzero_q) begin
                    q_d   = nsign_q ? QNegSat : QPosSat;
                    r_d   = '0;
                    ovf_d = 1'b0;
                    dz_d  = 1'b1;
                end else begin
                    dz_d = 1'b0;
                    // Remainder follows the dividend sign; negating zero stays zero
                    r_d  = nsign_q ? -rem_q : rem_q;
                    if (qsign_q) begin
                        // Magnitude of exactly 2^(DW-1) is representable when negative
                        if (quo_q > NegMax) begin
                            q_d   = QNegSat;
                            ovf_d = 1'b1;
                        end else begin
                            q_d   = -quo_q[DW-1:0];
                            ovf_d = 1'b0;
                        end
                    end else begin
                        if (quo_q > PosMax) begin
                            q_d   = QPosSat;
                            ovf_d = 1'b1;
                        end else begin
                            q_d   = quo_q[DW-1:0];
                            ovf_d = 1'b0;
                        end
                    end
                end
            end

            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset that also clears the datapath
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dmag_q  <= '0;
            nsign_q <= 1'b0;
            qsign_q <= 1'b0;
            dzero_q <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dmag_q  <= dmag_d;
            nsign_q <= nsign_d;
            qsign_q <= qsign_d;
            dzero_q <= dzero_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    assign Q    = q_q;
    assign R    = r_q;
    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;
    assign dz   = dz_q;

endmodule

// File: doc/signed_divider32.md
SIGNED_DIVIDER32 -- requirements
Module: signed_divider32

Interface
REQ-001 The block SHALL have parameter NW, default 32, giving the dividend width; only the default is supported and verified.
REQ-002 The block SHALL have parameter DW, default 16, giving the divisor, quotient and remainder width; only the default is supported and verified.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-006 The block SHALL have port N, input, 32 bits: two's-complement dividend, e.g. a full product word from the multiplier.
REQ-007 The block SHALL have port D, input, 16 bits: two's-complement divisor.
REQ-008 The block SHALL have port Q, output, 16 bits: two's-complement quotient, registered.
REQ-009 The block SHALL have port R, output, 16 bits: two's-complement remainder, registered.
REQ-010 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when Q/R/ovf/dz are updated.
REQ-012 The block SHALL have port ovf, output, 1 bit: the quotient saturated.
REQ-013 The block SHALL have port dz, output, 1 bit: the divisor was zero.

Function
REQ-014 The block SHALL implement states IDLE, DIV and FIX: IDLE->DIV on start=1, DIV->FIX after 32 iterations, FIX->IDLE unconditionally.
REQ-015 The block SHALL capture |N| (32-bit unsigned), |D| (16-bit unsigned), sign(N), sign(N) XOR sign(D) and D==0 on the edge sampling start (edge 0), and SHALL set busy=1 on that edge.
REQ-016 The block SHALL ignore N and D after edge 0 and SHALL ignore start whenever the state is not IDLE.
REQ-017 The block SHALL perform one restoring-division step per edge on edges 1..32, producing a 32-bit magnitude quotient and a 16-bit magnitude remainder (MSB first, shift-subtract against |D|).
REQ-018 On edge 33 (FIX) the block SHALL write Q, R, ovf and dz, set done=1 and busy=0; done SHALL fall at edge 34.
REQ-019 Latency SHALL be identical for all operands, including the divide-by-zero case.
REQ-020 Rounding SHALL be truncation toward zero; R SHALL carry the sign of N, and R=0 SHALL be emitted as 0x0000.
REQ-021 A positive result greater than 32767 SHALL give Q=0x7FFF and ovf=1; a negative result less than -32768 SHALL give Q=0x8000 and ovf=1; R SHALL still be the exact remainder.
REQ-022 A result of exactly -32768 SHALL give Q=0x8000 with ovf=0.
REQ-023 When D==0 the block SHALL give Q=0x7FFF if N>=0 or 0x8000 if N<0, with R=0x0000, dz=1 and ovf=0.
REQ-024 N=0x80000000 SHALL be handled: its magnitude 2^31 fits unsigned in 32 bits.
REQ-025 Q, R, ovf and dz SHALL hold their values until the next FIX edge.
REQ-026 start=1 during the done cycle SHALL be accepted (state is IDLE), giving a back-to-back period of 34 edges.

Reset
REQ-027 RST=1 on an edge SHALL force state=IDLE, Q=0x0000, R=0x0000, busy=0, done=0, ovf=0 and dz=0, overriding start.
REQ-028 Reset during DIV or FIX SHALL abort the operation, produce no done pulse and leave no residual state; the next start SHALL run normally.

Verification
REQ-029 The bench SHALL drive N=100, D=7 with start at edge 0 and SHALL check Q=0x000E, R=0x0002, done high only between edges 33 and 34, and busy high between edges 0 and 33.
REQ-030 The bench SHALL drive N=0xFFFFFF9C (-100), D=7 and check Q=0xFFF2, R=0xFFFE, ovf=0, then N=100, D=0xFFF9 (-7) and check Q=0xFFF2, R=0x0002.
REQ-031 The bench SHALL drive N=0x00FF0000, D=0x0100 and check Q=0x7FFF, R=0x0000, ovf=1; then N=0x40000000, D=0x8000 and check Q=0x8000, ovf=0.
REQ-032 The bench SHALL drive N=0xFFFFFFFB, D=0 and check Q=0x8000, R=0x0000, dz=1, ovf=0 at edge 33; then N=5, D=0 and check Q=0x7FFF.
REQ-033 The bench SHALL start N=1000, D=3, pulse start and change N/D at edge 5, assert RST at edge 10, and check busy=0 and Q=0 with no done pulse; a new N=9, D=3 start SHALL then give Q=3, R=0.
REQ-034 The bench SHALL hold start=1 continuously with N=-7, D=2 and check done pulses every 34 edges with Q=0xFFFD and R=0xFFFF.
